// File: rtl/psum_writeback_if.sv
// psum_writeback_if: bundles the sum input stream and the SRAM write port.
//  in_valid/in_data/in_ready : signed sums from the adder stage (ready/valid)
//  mem_we/mem_addr/mem_wdata/mem_ready : SRAM write request, accepted when mem_we && mem_ready
//  slave modport = psum_writeback side, master modport = driver/SRAM side
interface psum_writeback_if #(
  parameter int INTERNAL_BITS = 32,
  parameter int ADDR_BITS     = 16
);
  logic                     in_valid, in_ready, mem_we, mem_ready;
  logic [INTERNAL_BITS-1:0] in_data, mem_wdata;
  logic [ADDR_BITS-1:0]     mem_addr;
  modport master(output in_valid, in_data, mem_ready, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave(input in_valid, in_data, mem_ready, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/psum_writeback.sv
// psum_writeback: writes a tile of accumulated sums to SRAM, raw or requantized to DATA_BITS.
//  clk, rst_n          clock, asynchronous active-low reset
//  start_i             command pulse, honoured in IDLE; latches base_addr_i, length_i,
//                      final_pass_i, relu_en_i
//  busy_o, done_o      high in RUN / 1-cycle pulse when the tile completes
//  wb                  sum input stream and SRAM write port (slave modport)
module psum_writeback #(
  parameter int INTERNAL_BITS = 32,
  parameter int DATA_BITS     = 16,
  parameter int ADDR_BITS     = 16,
  parameter int SHIFT         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] base_addr_i,
  input  logic [ADDR_BITS-1:0] length_i,
  input  logic                 final_pass_i,
  input  logic                 relu_en_i,
  output logic                 busy_o,
  output logic                 done_o,
  psum_writeback_if.slave      wb
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic signed [INTERNAL_BITS:0] HALF = (INTERNAL_BITS+1)'(1) << (SHIFT-1);
  localparam logic signed [INTERNAL_BITS-1:0] DMAX = INTERNAL_BITS'((64'd1 << (DATA_BITS-1)) - 64'd1);
  localparam logic signed [INTERNAL_BITS-1:0] DMIN = ~DMAX;
  state_t state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, len_q, in_cnt_q, wr_cnt_q, s1_a_q, s2_a_q;
  logic final_q, relu_q, s1_v_q, s2_v_q;
  logic signed [INTERNAL_BITS-1:0] s1_d_q, s2_d_q, s1_d, relu_v, s2_d;
  logic signed [INTERNAL_BITS:0] rnd;
  logic go, adv, take, wr_fire;
  assign go         = state_q == IDLE && start_i;
  assign adv        = !s2_v_q || wb.mem_ready;
  assign wb.in_ready = state_q == RUN && in_cnt_q < len_q && adv;
  assign take       = wb.in_valid && wb.in_ready;
  assign wr_fire    = s2_v_q && wb.mem_ready;
  // one extra bit so adding the rounding constant cannot overflow
  assign rnd    = {wb.in_data[INTERNAL_BITS-1], wb.in_data} + HALF;
  assign s1_d   = final_q ? INTERNAL_BITS'(rnd >>> SHIFT) : wb.in_data;
  assign relu_v = relu_q && s1_d_q[INTERNAL_BITS-1] ? '0 : s1_d_q;
  assign s2_d   = !final_q ? s1_d_q : relu_v > DMAX ? DMAX : relu_v < DMIN ? DMIN : relu_v;
  assign wb.mem_we    = s2_v_q;
  assign wb.mem_addr  = s2_a_q;
  assign wb.mem_wdata = s2_d_q;
  assign busy_o = state_q == RUN;
  assign done_o = state_q == DONE;
  always_comb begin
    state_d = state_q;
    if (go) state_d = length_i == '0 ? DONE : RUN;
    else if (state_q == RUN && wr_fire && wr_cnt_q + ADDR_BITS'(1) == len_q) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      final_q  <= 1'b0;
      relu_q   <= 1'b0;
      in_cnt_q <= '0;
      wr_cnt_q <= '0;
      s1_v_q   <= 1'b0;
      s1_d_q   <= '0;
      s1_a_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_d_q   <= '0;
      s2_a_q   <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        base_q   <= base_addr_i;
        len_q    <= length_i;
        final_q  <= final_pass_i;
        relu_q   <= relu_en_i;
        in_cnt_q <= '0;
        wr_cnt_q <= '0;
      end else begin
        in_cnt_q <= in_cnt_q + ADDR_BITS'(take);
        wr_cnt_q <= wr_cnt_q + ADDR_BITS'(wr_fire);
      end
      // writes retire in order, so the input index doubles as the write index
      if (adv) begin
        s1_v_q <= take;
        s1_d_q <= s1_d;
        s1_a_q <= base_q + in_cnt_q;
        s2_v_q <= s1_v_q;
        s2_d_q <= s2_d;
        s2_a_q <= s1_a_q;
      end
    end
  end
endmodule
